board_renderer: RTL and testbench



---
 rtl/board_renderer_pkg.sv | 46 ++++
 rtl/board_renderer_if.sv | 37 +++
 rtl/board_renderer_tile_walker.sv | 100 ++++++++++
 rtl/board_renderer.sv | 138 +++++++++++++
 tb/tb_board_renderer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_renderer_pkg
// Description : Shared definitions for the Sokoban board renderer.
//               - Sprite id constants shared with sprite_draw and game logic.
//               - 3-bit renderer state encoding.
//               - Screen limits and command field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package board_renderer_pkg;

    typedef enum logic [3:0] {
        SPR_EMPTY       = 4'd0,
        SPR_WALL        = 4'd1,
        SPR_BOX         = 4'd2,
        SPR_GOAL        = 4'd3,
        SPR_PLAYER      = 4'd4,
        SPR_BOX_ON_GOAL = 4'd5
    } sprite_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_RDWAIT = 3'd2,
        S_LATCH  = 3'd3,
        S_REQ    = 3'd4,
        S_WAIT   = 3'd5,
        S_NEXT   = 3'd6,
        S_FIN    = 3'd7
    } state_e;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int ADDR_W = 7;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int ID_W   = 4;

    // True when a grid of n tiles of the given edge, starting at org, fits in lim.
    function automatic bit fits_screen(input int org, input int n, input int tile, input int lim);
        return (org + n * tile) <= lim;
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : board_renderer_if
// Description : Bundle of the renderer's control, board-RAM and sprite-draw
//               command signals.
//               master : the renderer (drives busy/frame_done, RAM address,
//                        draw command fields and begin_draw)
//               slave  : the environment (game logic start, RAM data,
//                        drawer draw_done)
// Revision    : 1.0 - initial release
// ============================================================================
interface board_renderer_if;
    import board_renderer_pkg::*;

    logic              start;
    logic              busy;
    logic              frame_done;
    logic [ADDR_W-1:0] board_addr;
    logic [ID_W-1:0]   board_data;
    logic [X_W-1:0]    x_out;
    logic [Y_W-1:0]    y_out;
    logic [ID_W-1:0]   sprite_id_out;
    logic              begin_draw;
    logic              draw_done;

    modport master (
        input  start, board_data, draw_done,
        output busy, frame_done, board_addr, x_out, y_out, sprite_id_out, begin_draw
    );

    modport slave (
        output start, board_data, draw_done,
        input  busy, frame_done, board_addr, x_out, y_out, sprite_id_out, begin_draw
    );

endinterface
`default_nettype wire

// File: rtl/board_renderer_tile_walker.sv
`default_nettype none
// ============================================================================
// Module      : board_renderer_tile_walker
// Description : Row-major tile position tracker for the board renderer.
//               Keeps column/row counters, a linear RAM address and pixel
//               x/y accumulators (adders only). One step per advance_i;
//               stepping past the last tile wraps back to tile (0,0).
// Ports       : clk, resetn   - clock, async active-low reset
//               advance_i     - move to the next tile
//               addr_o        - row*GRID_W+col
//               x_o, y_o      - pixel origin of the current tile
//               last_o        - current tile is (GRID_W-1, GRID_H-1)
// Revision    : 1.0 - initial release
// ============================================================================
module board_renderer_tile_walker
    import board_renderer_pkg::*;
#(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10,
    parameter int TILE   = 12,
    parameter int X_ORG  = 20,
    parameter int Y_ORG  = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [X_W-1:0]    x_o,
    output logic [Y_W-1:0]    y_o,
    output logic              last_o
);

    localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    localparam logic [CW-1:0]  COL_LAST = CW'(GRID_W - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(GRID_H - 1);
    localparam logic [X_W-1:0] X0       = X_W'(X_ORG);
    localparam logic [Y_W-1:0] Y0       = Y_W'(Y_ORG);
    localparam logic [X_W-1:0] STEP_X   = X_W'(TILE);
    localparam logic [Y_W-1:0] STEP_Y   = Y_W'(TILE);

    logic [CW-1:0]     col_q,  col_d;
    logic [RW-1:0]     row_q,  row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [X_W-1:0]    x_q,    x_d;
    logic [Y_W-1:0]    y_q,    y_d;

    assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        x_d    = x_q;
        y_d    = y_q;
        if (advance_i) begin
            if (last_o) begin
                // Wrap so the next frame starts from tile (0,0).
                col_d  = '0;
                row_d  = '0;
                addr_d = '0;
                x_d    = X0;
                y_d    = Y0;
            end else if (col_q == COL_LAST) begin
                col_d  = '0;
                row_d  = row_q + RW'(1);
                addr_d = addr_q + ADDR_W'(1);
                x_d    = X0;
                y_d    = y_q + STEP_Y;
            end else begin
                col_d  = col_q + CW'(1);
                addr_d = addr_q + ADDR_W'(1);
                x_d    = x_q + STEP_X;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            x_q    <= X0;
            y_q    <= Y0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign addr_o = addr_q;
    assign x_o    = x_q;
    assign y_o    = y_q;

endmodule
`default_nettype wire

// File: rtl/board_renderer.sv
`default_nettype none
// ============================================================================
// Module      : board_renderer
// Description : Walks the Sokoban board RAM tile by tile and issues one
//               sprite-draw command (x, y, sprite id, begin_draw strobe) per
//               tile, waiting for draw_done before moving on. One full frame
//               per accepted start; frame_done pulses after the last tile.
//               Optional build macro SKIP_EMPTY_EN: tiles whose id is 0
//               (floor) issue no command.
// Ports       : clk, resetn - clock, async active-low reset
//               bus         - board_renderer_if.master (start/busy/
//                             frame_done, board RAM, draw command)
// Revision    : 1.0 - initial release
// ============================================================================
module board_renderer
    import board_renderer_pkg::*;
#(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10,
    parameter int TILE   = 12,
    parameter int X_ORG  = 20,
    parameter int Y_ORG  = 0
) (
    input  logic             clk,
    input  logic             resetn,
    board_renderer_if.master bus
);

    state_e            state_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              begin_draw_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [ID_W-1:0]   sprite_q;

    logic              w_advance;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;
    logic [X_W-1:0]    w_x;
    logic [Y_W-1:0]    w_y;

    assign w_advance = (state_q == S_NEXT);

    board_renderer_tile_walker #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .TILE   (TILE),
        .X_ORG  (X_ORG),
        .Y_ORG  (Y_ORG)
    ) u_walker (
        .clk       (clk),
        .resetn    (resetn),
        .advance_i (w_advance),
        .addr_o    (w_addr),
        .x_o       (w_x),
        .y_o       (w_y),
        .last_o    (w_last)
    );

    // All outputs are registered: strobes are set on the transition into the
    // state they belong to, so they are high exactly while in that state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            begin_draw_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            sprite_q     <= '0;
        end else begin
            begin_draw_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_ADDR;
                        busy_q  <= 1'b1;
                    end
                end
                // The address counter is already on board_addr; the RAM
                // samples it here and its output is stable by LATCH.
                S_ADDR:   state_q <= S_RDWAIT;
                S_RDWAIT: state_q <= S_LATCH;
                S_LATCH: begin
                    sprite_q <= bus.board_data;
                    x_q      <= w_x;
                    y_q      <= w_y;
`ifdef SKIP_EMPTY_EN
                    if (bus.board_data == SPR_EMPTY) begin
                        state_q <= S_NEXT;
                    end else begin
                        state_q      <= S_REQ;
                        begin_draw_q <= 1'b1;
                    end
`else
                    state_q      <= S_REQ;
                    begin_draw_q <= 1'b1;
`endif
                end
                // draw_done is deliberately not looked at in REQ.
                S_REQ: state_q <= S_WAIT;
                S_WAIT: begin
                    if (bus.draw_done) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        state_q      <= S_FIN;
                        frame_done_q <= 1'b1;
                    end else begin
                        state_q <= S_ADDR;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.begin_draw    = begin_draw_q;
    assign bus.board_addr    = w_addr;
    assign bus.x_out         = x_q;
    assign bus.y_out         = y_q;
    assign bus.sprite_id_out = sprite_q;

endmodule
`default_nettype wire

// File: tb/tb_board_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_renderer
// Description : Self-checking bench for board_renderer. A sync-RAM model and
//               a sprite-drawer model surround the DUT; expected commands
//               are queued when a frame is started and compared as each
//               begin_draw appears, including start/draw_done latency.
//               Honours SKIP_EMPTY_EN when the build defines it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_renderer;
    import board_renderer_pkg::*;

    localparam int GRID_W = 10;
    localparam int GRID_H = 10;
    localparam int TILE   = 12;
    localparam int X_ORG  = 20;
    localparam int Y_ORG  = 0;
    localparam int NT     = GRID_W * GRID_H;
    localparam int BOUND  = 6000;
`ifdef SKIP_EMPTY_EN
    localparam int EXP_MOD16 = 93;
    localparam int EXP_EMPTY = 0;
`else
    localparam int EXP_MOD16 = 100;
    localparam int EXP_EMPTY = 100;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    board_renderer_if bif ();

    board_renderer #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .TILE   (TILE),
        .X_ORG  (X_ORG),
        .Y_ORG  (Y_ORG)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- board RAM model (1-cycle read latency) ----------------
    logic [3:0] mem [0:127];
    logic [3:0] ram_q = 4'd0;
    always @(posedge clk) ram_q <= mem[bif.board_addr];
    assign bif.board_data = ram_q;

    // ---------------- sprite drawer model -----------------------------------
    logic dd_model = 1'b0;
    logic dd_spur  = 1'b0;
    assign bif.draw_done = dd_model | dd_spur;

    int pend     = -1;
    int dd_cyc   = 0;
    int hold_x   = 255;
    int hold_y   = 255;
    int hold_len = 1000;

    initial forever begin
        @(negedge clk);
        dd_model = 1'b0;
        if (!resetn) begin
            pend = -1;
        end else if (bif.begin_draw) begin
            pend = (int'(bif.x_out) == hold_x && int'(bif.y_out) == hold_y) ? hold_len : 3;
        end else if (pend == 1) begin
            dd_model = 1'b1;
            dd_cyc   = cyc;
            pend     = -1;
        end else if (pend > 1) begin
            pend = pend - 1;
        end
    end

    // ---------------- scoreboard --------------------------------------------
    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [3:0] id;
        int         skips;
    } exp_t;

    exp_t sb[$];
    int   n_vec     = 0;
    int   n_fail    = 0;
    int   n_pulses  = 0;
    int   n_fd      = 0;
    int   start_cyc = 0;
    bit   first_pending = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [3:0] ram_val(input int mode, input int k);
        case (mode)
            0:       return 4'd2;
            1:       return 4'(k % 16);
            default: return 4'd0;
        endcase
    endfunction

    task automatic load_ram(input int mode);
        for (int k = 0; k < 128; k++) mem[k] = ram_val(mode, k);
    endtask

    task automatic push_frame(input int mode);
        int   skips;
        exp_t e;
        skips = 0;
        for (int k = 0; k < NT; k++) begin
`ifdef SKIP_EMPTY_EN
            if (ram_val(mode, k) == 4'd0) begin
                skips++;
                continue;
            end
`endif
            e.x     = 8'(X_ORG + TILE * (k % GRID_W));
            e.y     = 7'(Y_ORG + TILE * (k / GRID_W));
            e.id    = ram_val(mode, k);
            e.skips = skips;
            sb.push_back(e);
            skips = 0;
        end
    endtask

    // Command monitor: every begin_draw is matched against the queue head,
    // including its distance from start (first command) or last draw_done.
    initial forever begin
        exp_t e;
        int   lat;
        int   lat_req;
        @(negedge clk);
        if (resetn && bif.begin_draw) begin
            n_pulses++;
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL extra_cmd actual=(%0d,%0d,id%0d) required=no command",
                         bif.x_out, bif.y_out, bif.sprite_id_out);
            end else begin
                e       = sb.pop_front();
                lat_req = (first_pending ? 4 : 5) + 4 * e.skips;
                lat     = first_pending ? (cyc - start_cyc) : (cyc - dd_cyc);
                first_pending = 1'b0;
                if (bif.x_out !== e.x || bif.y_out !== e.y ||
                    bif.sprite_id_out !== e.id || lat != lat_req) begin
                    n_fail++;
                    $display("FAIL cmd%0d actual=(%0d,%0d,id%0d,lat%0d) required=(%0d,%0d,id%0d,lat%0d)",
                             n_pulses, bif.x_out, bif.y_out, bif.sprite_id_out, lat,
                             e.x, e.y, e.id, lat_req);
                end
            end
        end
        if (resetn && bif.frame_done) begin
            n_fd++;
            chk("busy_at_frame_done", int'(bif.busy), 1);
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},       int'(bif.busy),          0);
        chk({tag, "_frame_done"}, int'(bif.frame_done),    0);
        chk({tag, "_begin_draw"}, int'(bif.begin_draw),    0);
        chk({tag, "_addr"},       int'(bif.board_addr),    0);
        chk({tag, "_x"},          int'(bif.x_out),         0);
        chk({tag, "_y"},          int'(bif.y_out),         0);
        chk({tag, "_sprite"},     int'(bif.sprite_id_out), 0);
    endtask

    // Runs one frame from the current negedge. disturb adds a draw_done in
    // IDLE, one in a REQ cycle and a start mid-frame; fd_start raises start
    // while frame_done is high and returns one cycle after FIN.
    task automatic run_frame(input int mode, input int hold_tile, input bit disturb,
                             input int exp_pulses, input bit fd_start);
        int base;
        int fd_base;
        int local_p;
        int hold_seen;
        bit done;
        local_p   = 0;
        hold_seen = -1;
        done      = 1'b0;
        load_ram(mode);
        if (hold_tile >= 0) begin
            hold_x = X_ORG + TILE * (hold_tile % GRID_W);
            hold_y = Y_ORG + TILE * (hold_tile / GRID_W);
        end else begin
            hold_x = 255;
            hold_y = 255;
        end
        if (disturb) begin
            dd_spur = 1'b1;
            @(negedge clk);
            dd_spur = 1'b0;
            chk("idle_spurious_done_busy", int'(bif.busy), 0);
        end
        base    = n_pulses;
        fd_base = n_fd;
        push_frame(mode);
        start_cyc     = cyc;
        first_pending = 1'b1;
        bif.start     = 1'b1;
        for (int c = 1; c <= BOUND && !done; c++) begin
            @(negedge clk);
            bif.start = disturb && (c == 150);
            dd_spur   = 1'b0;
            if (bif.begin_draw) begin
                local_p++;
                if (disturb && local_p == 3) dd_spur = 1'b1;
                if (int'(bif.x_out) == hold_x && int'(bif.y_out) == hold_y) hold_seen = c;
            end
            if (hold_seen > 0 && c == hold_seen + 500) begin
                chk("hold_begin_draw", int'(bif.begin_draw),    0);
                chk("hold_x",          int'(bif.x_out),         hold_x);
                chk("hold_y",          int'(bif.y_out),         hold_y);
                chk("hold_sprite",     int'(bif.sprite_id_out), int'(ram_val(mode, hold_tile)));
                chk("hold_busy",       int'(bif.busy),          1);
            end
            if (bif.frame_done) begin
                done = 1'b1;
                if (fd_start) bif.start = 1'b1;
            end
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL frame_timeout actual=no frame_done required=frame_done within %0d cycles", BOUND);
            bif.start = 1'b0;
            sb.delete();
        end else begin
            @(negedge clk);
            bif.start = 1'b0;
            chk("busy_after_frame",       int'(bif.busy),       0);
            chk("frame_done_one_cycle",   int'(bif.frame_done), 0);
            chk("cmd_count",              n_pulses - base,      exp_pulses);
            chk("frame_done_count",       n_fd - fd_base,       1);
            chk("scoreboard_empty",       sb.size(),            0);
            if (!fd_start) begin
                repeat (30) @(negedge clk);
                chk("no_extra_cmds",  n_pulses - base, exp_pulses);
                chk("no_extra_frame", n_fd - fd_base,  1);
                chk("still_idle",     int'(bif.busy),  0);
            end
        end
    endtask

    typedef struct {
        int mode;
        int hold_tile;
        bit disturb;
        int exp_pulses;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int local_p;
        bit got;
        bif.start = 1'b0;
        if (!fits_screen(X_ORG, GRID_W, TILE, SCREEN_W) || !fits_screen(Y_ORG, GRID_H, TILE, SCREEN_H)) begin
            $display("FAIL param_limits actual=grid off screen required=within %0dx%0d", SCREEN_W, SCREEN_H);
            $fatal(1, "parameter limits");
        end

        vecs[0] = '{mode: 0, hold_tile: -1, disturb: 1'b0, exp_pulses: 100};
        vecs[1] = '{mode: 1, hold_tile: -1, disturb: 1'b0, exp_pulses: EXP_MOD16};
        vecs[2] = '{mode: 0, hold_tile: -1, disturb: 1'b1, exp_pulses: 100};
        vecs[3] = '{mode: 0, hold_tile:  5, disturb: 1'b0, exp_pulses: 100};
        vecs[4] = '{mode: 2, hold_tile: -1, disturb: 1'b0, exp_pulses: EXP_EMPTY};

        load_ram(0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].mode, vecs[i].hold_tile, vecs[i].disturb, vecs[i].exp_pulses, 1'b0);
        end

        // start during frame_done is dropped; start in the following cycle is taken.
        run_frame(0, -1, 1'b0, 100, 1'b1);
        run_frame(1, -1, 1'b0, EXP_MOD16, 1'b0);

        // Reset while waiting on tile 37, then a clean restart from tile 0.
        load_ram(0);
        hold_x = X_ORG + TILE * 7;
        hold_y = Y_ORG + TILE * 3;
        push_frame(0);
        start_cyc     = cyc;
        first_pending = 1'b1;
        bif.start     = 1'b1;
        local_p       = 0;
        got           = 1'b0;
        for (int c = 0; c < BOUND && !got; c++) begin
            @(negedge clk);
            bif.start = 1'b0;
            if (bif.begin_draw) local_p++;
            if (local_p == 38) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL tile37_timeout actual=%0d commands required=38", local_p);
        end else begin
            repeat (5) @(negedge clk);
            chk("wait37_addr", int'(bif.board_addr), 37);
            chk("wait37_x",    int'(bif.x_out),      104);
            chk("wait37_y",    int'(bif.y_out),      36);
            chk("wait37_busy", int'(bif.busy),       1);
            chk("wait37_bd",   int'(bif.begin_draw), 0);
            #2 resetn = 1'b0;
            #1 check_idle("abort");
        end
        resetn = 1'b0;
        sb.delete();
        first_pending = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_frame(0, -1, 1'b0, 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
